// File: rtl/repacker_frame_pkg.sv
// Shared types and helpers for the frame-aware bit-stream width converter.
// Covers the level-width helper, the min helper and the FILL/DRAIN state encoding.
package repacker_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  function automatic int lvl_w(input int buff);
    return $clog2(buff + 1);
  endfunction

  function automatic int min_bits(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/repacker_frame_if.sv
// Stream handshake bundle for repacker_frame: input words, output words, clear and occupancy.
interface repacker_frame_if #(
  parameter int IN   = 24,
  parameter int OUT  = 64,
  parameter int BUFF = 192
);
  import repacker_pkg::*;

  localparam int LW = lvl_w(BUFF);
  localparam int BW = $clog2(OUT + 1);

  logic            clear_i;
  logic            in_val_i;
  logic [IN-1:0]   in_data_i;
  logic            in_last_i;
  logic            in_rdy_o;
  logic            out_val_o;
  logic [OUT-1:0]  out_data_o;
  logic            out_last_o;
  logic [BW-1:0]   out_bits_o;
  logic            out_rdy_i;
  logic [LW-1:0]   level_o;

  modport master (
    output clear_i, in_val_i, in_data_i, in_last_i, out_rdy_i,
    input  in_rdy_o, out_val_o, out_data_o, out_last_o, out_bits_o, level_o
  );

  modport slave (
    input  clear_i, in_val_i, in_data_i, in_last_i, out_rdy_i,
    output in_rdy_o, out_val_o, out_data_o, out_last_o, out_bits_o, level_o
  );

endinterface

// File: rtl/repacker_frame.sv
// Packs IN-bit words into OUT-bit words LSB-first with cut-through, flushing the
// final partial word of each frame zero-padded and tagged with its bit count.
module repacker_frame #(
  parameter int IN   = 24,
  parameter int OUT  = 64,
  parameter int BUFF = 192
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  repacker_frame_if.slave   bus
);
  import repacker_pkg::*;

  localparam int LW = lvl_w(BUFF);
  localparam int AW = LW + 1;
  localparam int BW = $clog2(OUT + 1);

  if (BUFF < IN + OUT) begin : g_bad_buff
    $error("repacker_frame: BUFF must be at least IN+OUT");
  end

  logic [BUFF-1:0] mem_q;
  logic [LW-1:0]   level_q;
  state_e          state_q;

  logic            tail;
  logic            rdy;
  logic            push;
  logic            pop;
  logic            tail_next;
  logic            val;
  logic            last;
  logic [AW-1:0]   avail;
  logic [BW-1:0]   bits;
  logic [OUT-1:0]  mask;
  logic [BUFF-1:0] merged;

  // Ready looks only at registered state and clear so it never depends on out_rdy_i.
  always_comb begin
    tail      = (state_q == DRAIN);
    rdy       = rst_ni & !tail & !bus.clear_i &
                ((AW'(level_q) + AW'(IN)) <= AW'(BUFF));
    push      = bus.in_val_i & rdy;
    avail     = AW'(level_q) + (push ? AW'(IN) : '0);
    merged    = mem_q | (push ? ({{(BUFF-IN){1'b0}}, bus.in_data_i} << level_q) : '0);
    tail_next = tail | (push & bus.in_last_i);
    val       = rst_ni & !bus.clear_i &
                ((avail >= AW'(OUT)) | (tail_next & (avail != '0)));
    bits      = BW'(min_bits(int'(avail), OUT));
    last      = tail_next & (avail <= AW'(OUT));
    mask      = (bits == BW'(OUT)) ? '1 : ((OUT'(1) << bits) - OUT'(1));
    pop       = val & bus.out_rdy_i;
  end

  assign bus.in_rdy_o   = rdy;
  assign bus.out_val_o  = val;
  assign bus.out_data_o = merged[OUT-1:0] & mask;
  assign bus.out_bits_o = bits;
  assign bus.out_last_o = last;
  assign bus.level_o    = level_q;

  // A popped last word empties the buffer and returns to FILL, which also covers cut-through.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      level_q <= '0;
      state_q <= FILL;
    end else if (bus.clear_i) begin
      mem_q   <= '0;
      level_q <= '0;
      state_q <= FILL;
    end else if (pop && last) begin
      mem_q   <= '0;
      level_q <= '0;
      state_q <= FILL;
    end else if (pop) begin
      mem_q   <= merged >> OUT;
      level_q <= LW'(avail - AW'(bits));
      state_q <= tail_next ? DRAIN : FILL;
    end else begin
      mem_q   <= merged;
      level_q <= LW'(avail);
      state_q <= tail_next ? DRAIN : FILL;
    end
  end

endmodule
